// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding and width defaults.
package pipe_ctrl_pkg;

   localparam int unsigned PC_W_DEF  = 32;
   localparam int unsigned CNT_W_DEF = 32;

   typedef logic [1:0] state_t;

   localparam state_t StRun        = 2'd0;
   localparam state_t StFreeze     = 2'd1;
   localparam state_t StFreezePend = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous active-high clear.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: merges hazard-unit decisions with cache-miss freezes and
// replays any redirect that resolved while the pipe was frozen.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_stall,
   input  logic             hazard_flush,
   input  logic [PC_W-1:0]  redirect_target,
   input  logic             icache_stall,
   input  logic             dcache_stall,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pc_redirect_valid,
   output logic [PC_W-1:0]  pc_redirect_addr,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_flush_cnt
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pend_addr_q, pend_addr_d;

   logic mem_stall;
   logic redirect;
   logic load_use;
   logic stall_inc;

   assign mem_stall = icache_stall | dcache_stall;
   assign redirect  = hazard_flush & ~hazard_stall;
   assign load_use  = hazard_stall;

   // Mealy outputs; priority is mem_stall > pending replay > redirect > load_use.
   always_comb begin
      pc_en             = 1'b1;
      if_id_en          = 1'b1;
      id_ex_en          = 1'b1;
      ex_mem_en         = 1'b1;
      mem_wb_en         = 1'b1;
      if_id_flush       = 1'b0;
      id_ex_bubble      = 1'b0;
      pc_redirect_valid = 1'b0;
      pc_redirect_addr  = '0;
      if (!rst) begin
         if (mem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
         end else if (state_q == StFreezePend) begin
            if_id_flush       = 1'b1;
            pc_redirect_valid = 1'b1;
            pc_redirect_addr  = pend_addr_q;
         end else if (redirect) begin
            if_id_flush       = 1'b1;
            pc_redirect_valid = 1'b1;
            pc_redirect_addr  = redirect_target;
         end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
         end
      end
   end

   // Once a redirect is pending, later ones during the same freeze are dropped (first wins).
   always_comb begin
      state_d     = state_q;
      pend_addr_d = pend_addr_q;
      if (mem_stall) begin
         if (state_q != StFreezePend) begin
            if (redirect) begin
               state_d     = StFreezePend;
               pend_addr_d = redirect_target;
            end else begin
               state_d = StFreeze;
            end
         end
      end else begin
         state_d = StRun;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         pend_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   assign stall_inc = ~(pc_en & if_id_en & id_ex_en & ex_mem_en & mem_wb_en);

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (perf_stall_cnt)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (if_id_flush),
      .count (perf_flush_cnt)
   );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: pending-redirect model checked every cycle on two
// instances (32-bit and 4-bit counters) plus hand-computed directed expectations.
module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hazard_stall = 1'b0;
   logic        hazard_flush = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        icache_stall = 1'b0;
   logic        dcache_stall = 1'b0;

   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_flush, id_ex_bubble, pc_redirect_valid;
   logic [31:0] pc_redirect_addr;
   logic [31:0] perf_stall_cnt, perf_flush_cnt;

   logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
   logic        s_if_id_flush, s_id_ex_bubble, s_pc_redirect_valid;
   logic [31:0] s_pc_redirect_addr;
   logic [3:0]  s_perf_stall_cnt, s_perf_flush_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .hazard_stall      (hazard_stall),
      .hazard_flush      (hazard_flush),
      .redirect_target   (redirect_target),
      .icache_stall      (icache_stall),
      .dcache_stall      (dcache_stall),
      .pc_en             (pc_en),
      .if_id_en          (if_id_en),
      .id_ex_en          (id_ex_en),
      .ex_mem_en         (ex_mem_en),
      .mem_wb_en         (mem_wb_en),
      .if_id_flush       (if_id_flush),
      .id_ex_bubble      (id_ex_bubble),
      .pc_redirect_valid (pc_redirect_valid),
      .pc_redirect_addr  (pc_redirect_addr),
      .perf_stall_cnt    (perf_stall_cnt),
      .perf_flush_cnt    (perf_flush_cnt)
   );

   pipe_stall_ctrl #(
      .PC_W  (32),
      .CNT_W (4)
   ) dut_sat (
      .clk               (clk),
      .rst               (rst),
      .hazard_stall      (hazard_stall),
      .hazard_flush      (hazard_flush),
      .redirect_target   (redirect_target),
      .icache_stall      (icache_stall),
      .dcache_stall      (dcache_stall),
      .pc_en             (s_pc_en),
      .if_id_en          (s_if_id_en),
      .id_ex_en          (s_id_ex_en),
      .ex_mem_en         (s_ex_mem_en),
      .mem_wb_en         (s_mem_wb_en),
      .if_id_flush       (s_if_id_flush),
      .id_ex_bubble      (s_id_ex_bubble),
      .pc_redirect_valid (s_pc_redirect_valid),
      .pc_redirect_addr  (s_pc_redirect_addr),
      .perf_stall_cnt    (s_perf_stall_cnt),
      .perf_flush_cnt    (s_perf_flush_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the only memory is whether a redirect is owed to the PC, and its address.
   bit          m_pending = 0;
   logic [31:0] m_addr    = '0;
   longint      m_stalls  = 0;
   longint      m_flushes = 0;

   always @(negedge clk) begin
      bit          ms, rd, any_frozen;
      logic [4:0]  e_en;
      logic        e_flush, e_bubble, e_valid;
      logic [31:0] e_addr;
      ms       = icache_stall | dcache_stall;
      rd       = hazard_flush & ~hazard_stall;
      e_en     = 5'b11111;
      e_flush  = 0;
      e_bubble = 0;
      e_valid  = 0;
      e_addr   = '0;
      if (!rst) begin
         if (ms) e_en = 5'b00000;
         else if (m_pending) begin
            e_flush = 1; e_valid = 1; e_addr = m_addr;
         end else if (rd) begin
            e_flush = 1; e_valid = 1; e_addr = redirect_target;
         end else if (hazard_stall) begin
            e_en = 5'b00111; e_bubble = 1;
         end
      end
      check("en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, e_en);
      check("flush", if_id_flush, e_flush);
      check("bubble", id_ex_bubble, e_bubble);
      check("redir_valid", pc_redirect_valid, e_valid);
      check("redir_addr", pc_redirect_addr, e_addr);
      check("stall_cnt", perf_stall_cnt, m_stalls);
      check("flush_cnt", perf_flush_cnt, m_flushes);
      check("sat_en", {s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en}, e_en);
      check("sat_redir", {s_if_id_flush, s_id_ex_bubble, s_pc_redirect_valid}, {e_flush, e_bubble,
            e_valid});
      check("sat_stall_cnt", s_perf_stall_cnt, (m_stalls > 15) ? 15 : m_stalls);
      check("sat_flush_cnt", s_perf_flush_cnt, (m_flushes > 15) ? 15 : m_flushes);
      // Advance the model across the coming clock edge.
      any_frozen = (e_en != 5'b11111);
      if (rst) begin
         m_pending = 0; m_addr = '0; m_stalls = 0; m_flushes = 0;
      end else begin
         if (any_frozen) m_stalls++;
         if (e_flush) m_flushes++;
         if (ms) begin
            if (!m_pending && rd) begin
               m_pending = 1; m_addr = redirect_target;
            end
         end else begin
            m_pending = 0;
         end
      end
   end

   // Inputs change 1 ns after the rising edge; returns just after the falling edge.
   task automatic drive(input logic r, input logic hs, input logic hf, input logic [31:0] tgt,
                        input logic ic, input logic dc);
      @(posedge clk);
      #1;
      rst = r; hazard_stall = hs; hazard_flush = hf; redirect_target = tgt;
      icache_stall = ic; dcache_stall = dc;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 32'h0, 0, 0);
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 32'h0, 0, 0);
   endtask

   initial begin
      do_reset();
      do_reset();
      check("rst_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);
      check("rst_stall_cnt", perf_stall_cnt, 0);
      idle();

      // Load-use.
      drive(0, 1, 1, 32'hdead_beef, 0, 0);
      check("lu_pc_en", pc_en, 0);
      check("lu_if_id_en", if_id_en, 0);
      check("lu_bubble", id_ex_bubble, 1);
      check("lu_rest_en", {id_ex_en, ex_mem_en, mem_wb_en}, 3'b111);
      check("lu_no_redir", pc_redirect_valid, 0);
      idle();
      check("lu_stall_cnt", perf_stall_cnt, 1);

      // Redirect in RUN.
      do_reset();
      drive(0, 0, 1, 32'h0000_0100, 0, 0);
      check("rd_valid", pc_redirect_valid, 1);
      check("rd_addr", pc_redirect_addr, 32'h100);
      check("rd_flush", if_id_flush, 1);
      idle();
      check("rd_flush_cnt", perf_flush_cnt, 1);

      // Redirects during a D-miss: the first one wins and is replayed on release.
      do_reset();
      drive(0, 0, 1, 32'h200, 0, 1);
      check("dm_frozen", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00000);
      drive(0, 0, 1, 32'h300, 0, 1);
      drive(0, 0, 0, 32'h0, 0, 1);
      drive(0, 1, 0, 32'h0, 0, 1);
      check("dm_frozen4", {pc_en, mem_wb_en, id_ex_bubble}, 3'b000);
      drive(0, 0, 0, 32'h0, 0, 0);
      check("dm_replay_addr", pc_redirect_addr, 32'h200);
      check("dm_replay_flush", if_id_flush, 1);
      check("dm_stall_cnt", perf_stall_cnt, 4);
      idle();
      check("dm_run_after", pc_redirect_valid, 0);
      check("dm_flush_cnt", perf_flush_cnt, 1);

      // Plain I-miss with load-use in the release cycle.
      do_reset();
      repeat (3) drive(0, 0, 0, 32'h0, 1, 0);
      check("im_frozen", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00000);
      drive(0, 1, 0, 32'h0, 0, 0);
      check("im_lu_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00111);
      check("im_lu_bubble", id_ex_bubble, 1);
      check("im_lu_no_flush", if_id_flush, 0);
      idle();
      check("im_run_en", {pc_en, if_id_en, id_ex_bubble}, 3'b110);
      check("im_stall_cnt", perf_stall_cnt, 4);

      // Reset while a redirect is pending discards it.
      do_reset();
      drive(0, 0, 1, 32'h400, 0, 1);
      drive(0, 0, 0, 32'h0, 0, 1);
      drive(1, 0, 0, 32'h0, 0, 1);
      idle();
      check("rp_no_redir", pc_redirect_valid, 0);
      check("rp_no_flush", if_id_flush, 0);
      check("rp_stall_cnt", perf_stall_cnt, 0);
      check("rp_flush_cnt", perf_flush_cnt, 0);

      // Saturation on the 4-bit instance.
      do_reset();
      repeat (20) drive(0, 0, 0, 32'h0, 0, 1);
      idle();
      check("sat_stall_hold", s_perf_stall_cnt, 4'hf);
      check("sat_stall_wide", perf_stall_cnt, 20);
      repeat (18) drive(0, 0, 1, 32'h80, 0, 0);
      idle();
      check("sat_flush_hold", s_perf_flush_cnt, 4'hf);
      check("sat_flush_wide", perf_flush_cnt, 18);

      // Mixed traffic checked by the model alone.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 60) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
